dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder for the RV32I core's load/store port. It sits on the memory side opposite the datapath's ALUResult/WriteData/ReadData path. It accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait states, and commits byte-strobed writes or returns full aligned read words. Range and strobe faults are reported with an error flag; load byte extraction stays in the core's load unit.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH 32-bit words (4 KiB at default)
WAIT_CYCLES, 2, wait states between request accept and access commit (0..15)

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, already lane-aligned by the core's store unit
req_wstrb  in  4  byte write enables, bit i covers req_wdata[8i+7:8i]
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts response
rsp_rdata  out  32  aligned read word (0 on writes and errors)
rsp_err  out  1  access fault for this response

Behaviour:
- FSM states are IDLE, WAIT and RESP. Reset forces IDLE with cnt=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0. req_ready is 1 whenever the FSM is in IDLE. Memory array contents are not reset.
- req_ready = (state==IDLE), decoded combinationally from the state register only and never from req_valid.
- In IDLE, the edge with req_valid&&req_ready latches we, addr, wdata and wstrb, loads cnt=WAIT_CYCLES and moves to WAIT. Request inputs are ignored in every other state.
- In WAIT with cnt!=0: decrement cnt each cycle.
- In WAIT with cnt==0: on that edge perform the access, register rsp_rdata and rsp_err, and move to RESP.
- rsp_valid rises exactly WAIT_CYCLES+1 edges after the accept edge.
- Error conditions, evaluated on latched values:
  - latched addr[31:ADDR_WIDTH+2] != 0 (out of range), or
  - a write whose wstrb is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- On error: no array update, rsp_rdata=0, rsp_err=1.
- Read with no error: rsp_rdata = mem[addr[ADDR_WIDTH+1:2]], rsp_err=0. addr[1:0] is ignored.
- Write with no error: each byte with wstrb[i]=1 is updated and other bytes are kept. rsp_rdata=0, rsp_err=0. addr[1:0] is ignored.
- In RESP, rsp_valid=1 and rsp_rdata/rsp_err are held stable until rsp_valid&&rsp_ready. On that edge rsp_valid drops to 0 and the FSM returns to IDLE.
- Only one transaction is outstanding at a time. Minimum spacing between accepts is WAIT_CYCLES+3 cycles with rsp_ready held high.
- Read-after-write: a read accepted after a write's response handshake returns the written data.
- Reset asserted mid-transaction: a write still in WAIT is discarded and never committed. A write already committed (FSM in RESP) stays in the array. All outputs return to their reset values immediately, since reset is asynchronous.
- WAIT_CYCLES=0: WAIT lasts exactly one cycle, so rsp_valid rises 1 edge after accept.

Test Plan:
- WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 with wstrb=1111 -> rsp_valid on the 3rd edge after accept, rsp_err=0, rsp_rdata=0. Then read 0x10 -> rsp_rdata=0xDEADBEEF. Reading 0x13 also returns 0xDEADBEEF.
- Byte write: wstrb=0100, wdata=0x00AA0000 to 0x12 after the above -> read 0x10 returns 0xDEAABEEF. Halfword write: wstrb=0011, wdata=0x00001234 -> read returns 0xDEAA1234.
- Faults:
  - read 0x00001000 (ADDR_WIDTH=10) -> rsp_err=1, rsp_rdata=0.
  - write 0x0 with wstrb=0101 -> rsp_err=1, and a following read of 0x0 shows the previous contents.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0; a req_valid pulse during this window is not accepted. After rsp_ready=1, req_ready=1 on the next cycle.
- Reset mid-WAIT: write 0x11111111 to 0x20 (preloaded with 0x22222222) and assert reset_n=0 one cycle after accept -> outputs immediately at reset values. After release, read 0x20 returns 0x22222222.
- WAIT_CYCLES=0: back-to-back reads with rsp_ready=1 -> accepts every 3 cycles, rsp_valid 1 edge after each accept.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder for the RV32I load/store port. Accepts one
//            request at a time over valid/ready, waits WAIT_CYCLES states,
//            then commits a byte-strobed store or returns an aligned read word.
//            Out-of-range addresses and illegal store strobes raise rsp_err.
// Ports    : clk, reset_n            - clock, async active-low reset
//            req_valid/req_ready     - request handshake
//            req_we/addr/wdata/wstrb - request fields (byte address)
//            rsp_valid/rsp_ready     - response handshake
//            rsp_rdata/rsp_err       - read word (0 on writes/faults), fault
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic                  mem_we;
  logic                  out_of_range;
  logic                  strb_ok;
  logic                  access_err;
  logic [ADDR_WIDTH-1:0] word_idx;

  // Any address bit above the array's byte range is a fault.
  assign out_of_range = (addr_q >> (ADDR_WIDTH + 2)) != 32'd0;
  assign word_idx     = addr_q[ADDR_WIDTH+1:2];

  // Only naturally shaped byte, halfword and word lane patterns are legal.
  always_comb begin
    case (wstrb_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: strb_ok = 1'b1;
      default:                   strb_ok = 1'b0;
    endcase
  end

  assign access_err = out_of_range || (we_q && !strb_ok);

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          if (access_err) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else if (we_q) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
            mem_we  = 1'b1;
          end else begin
            rdata_d = mem_q[word_idx];
            err_d   = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset. The commit strobe is decoded from state_q, which
  // reset holds in IDLE, so a store still waiting is dropped on reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem_q[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder. Expected
//            responses are queued when a request is driven and compared when
//            the response appears. A second instance runs with WAIT_CYCLES=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0, req_ready0, req_we0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_wstrb0;
  logic        rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int checks   = 0;
  int failures = 0;

  logic [32:0] sb  [$];
  logic [32:0] sb0 [$];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance. hold>0 stalls rsp_ready
  // for that many cycles and pokes a request in the middle of the stall.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    logic [32:0] e;
    int lat;
    sb.push_back({exp_err, exp_rdata});
    @(negedge clk);
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(W + 1));
    e = sb.pop_front();
    chk({tag, "/rdata"}, rsp_rdata, e[31:0]);
    chk({tag, "/err"}, 32'(rsp_err), 32'(e[32]));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, "/bp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "/bp_rdata"}, rsp_rdata, e[31:0]);
        chk({tag, "/bp_err"}, 32'(rsp_err), 32'(e[32]));
        chk({tag, "/bp_req_ready"}, 32'(req_ready), 32'd0);
        if (i == 1) begin
          req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0;
          req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
        end
        if (i == 3) req_valid = 1'b0;
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, "/bp_release_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "/bp_release_ready"}, 32'(req_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
      chk({tag, "/handshake"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  logic        w0_we    [6];
  logic [31:0] w0_addr  [6];
  logic [31:0] w0_wdata [6];

  initial begin
    logic [32:0] e;
    int op, cyc, last_acc;
    bit pend;

    reset_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0;
    rsp_ready = 1'b1;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'd0; req_wdata0 = 32'd0; req_wstrb0 = 4'd0;
    rsp_ready0 = 1'b1;

    @(negedge clk); @(negedge clk);
    chk("reset/req_ready", 32'(req_ready), 32'd1);
    chk("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset/rsp_rdata", rsp_rdata, 32'd0);
    chk("reset/rsp_err", 32'(rsp_err), 32'd0);
    reset_n = 1'b1;

    // Word write, aligned and unaligned reads
    xact("wr_word", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0);
    xact("rd_10",   1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);
    xact("rd_13",   1'b0, 32'h13, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);
    // Byte and halfword merges
    xact("wr_byte", 1'b1, 32'h12, 32'h00AA_0000, 4'b0100, 32'h0, 1'b0, 0);
    xact("rd_byte", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAA_BEEF, 1'b0, 0);
    xact("wr_half", 1'b1, 32'h10, 32'h0000_1234, 4'b0011, 32'h0, 1'b0, 0);
    xact("rd_half", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAA_1234, 1'b0, 0);
    // Faults
    xact("rd_oor",  1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    xact("wr_0",    1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 0);
    xact("wr_bad",  1'b1, 32'h0, 32'h1234_5678, 4'b0101, 32'h0, 1'b1, 0);
    xact("rd_0",    1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0);
    // Backpressure; the poked write to 0x0 must not be accepted
    xact("bp",      1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAA_1234, 1'b0, 5);
    xact("rd_0b",   1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0);

    // Reset while a store is in WAIT
    xact("wr_20",   1'b1, 32'h20, 32'h2222_2222, 4'hF, 32'h0, 1'b0, 0);
    xact("rd_20",   1'b0, 32'h20, 32'h0, 4'h0, 32'h2222_2222, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1111_1111; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid/req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid/rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid/rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mid/rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    xact("rd_20_after", 1'b0, 32'h20, 32'h0, 4'h0, 32'h2222_2222, 1'b0, 0);

    // WAIT_CYCLES=0 instance: requests held continuously, three writes then reads
    w0_we    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    w0_addr  = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
    w0_wdata = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'h0, 32'h0, 32'h0};
    op = 0; cyc = 0; last_acc = -1; pend = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_ready0) begin
        if (op < 6) begin
          req_valid0 = 1'b1; req_we0 = w0_we[op]; req_addr0 = w0_addr[op];
          req_wdata0 = w0_wdata[op]; req_wstrb0 = 4'hF;
          sb0.push_back(op < 3 ? 33'h0 : {1'b0, w0_wdata[op-3]});
          pend = 1'b1;
          op++;
        end else begin
          req_valid0 = 1'b0;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (pend) begin
        pend = 1'b0;
        if (last_acc >= 0) chk("w0/spacing", 32'(cyc - last_acc), 32'd3);
        last_acc = cyc;
      end
      if (rsp_valid0) begin
        chk("w0/latency", 32'(cyc - last_acc), 32'd1);
        if (sb0.size() > 0) begin
          e = sb0.pop_front();
          chk("w0/rdata", rsp_rdata0, e[31:0]);
          chk("w0/err", 32'(rsp_err0), 32'(e[32]));
        end else begin
          chk("w0/unexpected_rsp", 32'd1, 32'd0);
        end
      end
    end
    chk("w0/ops_done", 32'(op), 32'd6);
    chk("w0/sb_empty", 32'(sb0.size()), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
